fifo_umbral: RTL and testbench
==============================

Name: fifo_umbral

Overview:
- Single-clock synchronous FIFO with programmable almost-full/almost-empty thresholds.
- Sits directly upstream of the transaction control FSM. Five instances form the FIFO bank.
- Each instance drives one bit of the FSM's Fifo_empties and Fifo_errors buses.
- Thresholds are taken from the FSM's registered umbral outputs and latched when the FSM pulses init_out.

Parameters:
DATA_WIDTH, 6, width of each stored word
ADDR_WIDTH, 2, log2 of depth (depth = 2**ADDR_WIDTH = 4)
LENGTH, 3, threshold/occupancy width, must equal ADDR_WIDTH+1

Ports:
clk  input  1  rising-edge clock
reset_L  input  1  asynchronous, active-low reset
init  input  1  flush and threshold-load strobe (driven by FSM init_out)
umbral_alto  input  LENGTH  almost-full threshold, sampled on init
umbral_bajo  input  LENGTH  almost-empty threshold, sampled on init
push  input  1  write request
data_in  input  DATA_WIDTH  write data
pop  input  1  read request
data_out  output  DATA_WIDTH  read data, registered
valid_out  output  1  data_out valid this cycle
fifo_empty  output  1  occupancy == 0
fifo_full  output  1  occupancy == depth
almost_full  output  1  occupancy >= threshold_alto (threshold 0 disables)
almost_empty  output  1  occupancy <= threshold_bajo
fifo_error  output  1  sticky overflow/underflow flag
count  output  LENGTH  current occupancy

Behaviour:
- Reset (reset_L low, asynchronous):
  - Pointers and count = 0; data_out = 0; valid_out = 0; fifo_error = 0.
  - Both latched thresholds = 0.
  - Hence fifo_empty = 1, fifo_full = 0, almost_full = 0, almost_empty = 1.
  - Reset takes effect immediately and overrides all inputs, including a transfer mid-cycle.
- init (synchronous, highest priority after reset):
  - On an edge with init = 1: pointers and count cleared; fifo_error cleared; valid_out = 0.
  - umbral_alto and umbral_bajo latched into internal threshold registers.
  - push and pop in that cycle are ignored and flag no error.
- Write accepted when push = 1 and (count < depth, or pop is accepted in the same cycle):
  - data_in is stored at wr_ptr; wr_ptr increments modulo depth.
- Read accepted when pop = 1 and count > 0:
  - Word at rd_ptr is registered to data_out; valid_out = 1 on the next cycle (latency 1).
  - rd_ptr increments modulo depth.
- Cycles without an accepted read:
  - valid_out = 0 on the next cycle.
  - data_out holds its last value.
- Count update: +1 on write only, -1 on read only, unchanged on both or neither.
- Simultaneous push and pop:
  - Full: both accepted, count stays at depth, no error.
  - Empty: push accepted, pop rejected, fifo_error set (underflow).
- Overflow: push = 1, count == depth, no accepted pop -> write dropped, fifo_error set.
- Underflow: pop = 1, count == 0 -> no read, valid_out = 0 next cycle, fifo_error set.
- fifo_error is sticky: it stays 1 until init or reset, and further errors keep it at 1.
- Flag timing:
  - All status flags are combinational from the count register and the latched thresholds.
  - They therefore update in the same cycle the count changes.
- Pointer wrap: both pointers wrap from depth-1 to 0 without disturbing count.
- Comparisons are unsigned at LENGTH bits. A threshold greater than depth never asserts its flag, except almost_empty, which is then always 1.

Optional Feature:
- Macro: FIFO_ERR_COUNT_EN.
- Defined:
  - Adds output err_count [3:0], a saturating counter of error events (overflow or underflow cycles).
  - Increments by 1 per erroneous cycle and saturates at 15.
  - Cleared by reset and by init.
- Undefined:
  - No err_count port and no counter logic.
  - fifo_error behaviour is identical in both builds.

Test Plan:
- Reset then init with umbral_alto = 3, umbral_bajo = 1 -> fifo_empty = 1, almost_empty = 1, count = 0, fifo_error = 0.
- Push 0x0A, 0x15, 0x2C in 3 cycles -> count = 3, almost_full = 1, almost_empty = 0. Then 3 pops -> data_out = 0x0A, 0x15, 0x2C, each with valid_out = 1 one cycle after its pop.
- Fill to 4 words, then push 0x3F alone -> fifo_error = 1, count = 4, 0x3F never read. Then init -> fifo_error = 0, count = 0.
- Full FIFO, push 0x11 and pop simultaneously for 6 cycles -> count stays 4, no error, read order preserved across pointer wrap.
- Empty FIFO, push 0x05 with pop -> count = 1, fifo_error = 1, valid_out = 0. With FIFO_ERR_COUNT_EN, 20 further underflow cycles -> err_count = 15.
- Assert reset_L low mid-burst between clock edges -> all outputs reach reset values before the next edge.

Source files
------------

// File: rtl/fifo_umbral_if.sv
// fifo_umbral_if
//   Data handshake between a FIFO and the blocks around it.
//   Ports carried:
//     push      write request
//     data_in   write data
//     pop       read request
//     data_out  read data, registered inside the FIFO
//     valid_out data_out is valid this cycle
//   Modports:
//     master  the producer/consumer side (drives push/pop/data_in)
//     slave   the FIFO side (drives data_out/valid_out)
interface fifo_umbral_if #(
    parameter int DATA_WIDTH = 6
);
    logic                  push;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  pop;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;

    modport master (
        output push,
        output data_in,
        output pop,
        input  data_out,
        input  valid_out
    );

    modport slave (
        input  push,
        input  data_in,
        input  pop,
        output data_out,
        output valid_out
    );
endinterface

// File: rtl/fifo_umbral.sv
// fifo_umbral
//   Single-clock synchronous FIFO with programmable almost-full and
//   almost-empty thresholds, one of five instances in the FIFO bank that
//   feeds the transaction control FSM.
//
//   Ports:
//     clk          rising-edge clock
//     reset_L      asynchronous active-low reset
//     init         synchronous flush; also latches umbral_alto/umbral_bajo
//     umbral_alto  almost-full threshold (0 disables almost_full)
//     umbral_bajo  almost-empty threshold
//     bus          fifo_umbral_if.slave: push/data_in/pop/data_out/valid_out
//     fifo_empty   occupancy == 0
//     fifo_full    occupancy == depth
//     almost_full  occupancy >= latched alto threshold (when non-zero)
//     almost_empty occupancy <= latched bajo threshold
//     fifo_error   sticky overflow/underflow flag, cleared by init or reset
//     count        current occupancy
//     err_count    (only with FIFO_ERR_COUNT_EN) saturating error-cycle count
//
//   Optional feature macro: FIFO_ERR_COUNT_EN
module fifo_umbral #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 2,
    parameter int LENGTH     = 3
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              init,
    input  logic [LENGTH-1:0] umbral_alto,
    input  logic [LENGTH-1:0] umbral_bajo,
    fifo_umbral_if.slave      bus,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              fifo_error,
`ifdef FIFO_ERR_COUNT_EN
    output logic [3:0]        err_count,
`endif
    output logic [LENGTH-1:0] count
);

    localparam int              DEPTH_INT = 1 << ADDR_WIDTH;
    localparam logic [LENGTH-1:0] DEPTH   = LENGTH'(DEPTH_INT);

    logic [DATA_WIDTH-1:0] mem [DEPTH_INT];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [LENGTH-1:0]     count_q;
    logic [LENGTH-1:0]     thr_alto;
    logic [LENGTH-1:0]     thr_bajo;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  valid_q;
    logic                  error_q;

    logic                  rd_ok;
    logic                  wr_ok;
    logic                  overflow;
    logic                  underflow;
    logic                  err_ev;

    // Transfer qualification. init suppresses every transfer and error in
    // its cycle. A full FIFO still accepts a push when a pop drains a slot
    // in the same cycle.
    always_comb begin
        rd_ok     = !init && bus.pop && (count_q != '0);
        wr_ok     = !init && bus.push && ((count_q < DEPTH) || rd_ok);
        overflow  = !init && bus.push && (count_q == DEPTH) && !rd_ok;
        underflow = !init && bus.pop && (count_q == '0);
        err_ev    = overflow || underflow;
    end

    // Storage array carries no reset; only pointer/count state matters.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            thr_alto <= '0;
            thr_bajo <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else if (init) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            thr_alto <= umbral_alto;
            thr_bajo <= umbral_bajo;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
                dout_q <= mem[rd_ptr];
            end
            valid_q <= rd_ok;
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (err_ev) begin
                error_q <= 1'b1;
            end
        end
    end

`ifdef FIFO_ERR_COUNT_EN
    logic [3:0] err_cnt_q;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            err_cnt_q <= '0;
        end else if (init) begin
            err_cnt_q <= '0;
        end else if (err_ev && (err_cnt_q != 4'hF)) begin
            err_cnt_q <= err_cnt_q + 4'd1;
        end
    end

    assign err_count = err_cnt_q;
`endif

    // Status flags are purely combinational from count and thresholds, so
    // they move in the same cycle as count. A zero alto threshold disables
    // almost_full; a bajo threshold above depth pins almost_empty high.
    always_comb begin
        fifo_empty   = (count_q == '0);
        fifo_full    = (count_q == DEPTH);
        almost_full  = (thr_alto != '0) && (count_q >= thr_alto);
        almost_empty = (count_q <= thr_bajo);
    end

    assign count         = count_q;
    assign fifo_error    = error_q;
    assign bus.data_out  = dout_q;
    assign bus.valid_out = valid_q;

endmodule

// File: tb/tb_fifo_umbral.sv
// tb_fifo_umbral
//   Table-driven directed bench for fifo_umbral, plus hand-written
//   sequences for error saturation and asynchronous reset mid-burst.
//   Build with +define+FIFO_ERR_COUNT_EN to cover the err_count output.
module tb_fifo_umbral;

    localparam int DW = 6;
    localparam int LN = 3;

    logic          clk;
    logic          reset_L;
    logic          init;
    logic [LN-1:0] umbral_alto;
    logic [LN-1:0] umbral_bajo;
    logic          fifo_empty;
    logic          fifo_full;
    logic          almost_full;
    logic          almost_empty;
    logic          fifo_error;
    logic [LN-1:0] count;
`ifdef FIFO_ERR_COUNT_EN
    logic [3:0]    err_count;
`endif

    fifo_umbral_if #(.DATA_WIDTH(DW)) bus ();

    fifo_umbral #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(2),
        .LENGTH(LN)
    ) dut (
        .clk(clk),
        .reset_L(reset_L),
        .init(init),
        .umbral_alto(umbral_alto),
        .umbral_bajo(umbral_bajo),
        .bus(bus),
        .fifo_empty(fifo_empty),
        .fifo_full(fifo_full),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .fifo_error(fifo_error),
`ifdef FIFO_ERR_COUNT_EN
        .err_count(err_count),
`endif
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          init;
        logic [LN-1:0] alto;
        logic [LN-1:0] bajo;
        logic          push;
        logic          pop;
        logic [DW-1:0] din;
        logic          chk_d;
        logic [DW-1:0] dout;
        logic          valid;
        logic [LN-1:0] cnt;
        logic          empty;
        logic          full;
        logic          af;
        logic          ae;
        logic          err;
    } vec_t;

    vec_t vecs [$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(
        input logic i, input int a, input int b, input logic pu, input logic po,
        input int d, input logic cd, input int q, input logic v, input int c,
        input logic e, input logic f, input logic af, input logic ae,
        input logic er);
        vec_t t;
        t.init = i;  t.alto = LN'(a); t.bajo = LN'(b);
        t.push = pu; t.pop = po;      t.din = DW'(d);
        t.chk_d = cd; t.dout = DW'(q); t.valid = v; t.cnt = LN'(c);
        t.empty = e; t.full = f; t.af = af; t.ae = ae; t.err = er;
        return t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic i, input logic pu, input logic po, input int d);
        @(negedge clk);
        init        = i;
        bus.push    = pu;
        bus.pop     = po;
        bus.data_in = DW'(d);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_status(input string tag, input int c, input logic e,
                              input logic f, input logic af, input logic ae,
                              input logic er);
        chk({tag, ".count"}, int'(count), c);
        chk({tag, ".empty"}, int'(fifo_empty), int'(e));
        chk({tag, ".full"}, int'(fifo_full), int'(f));
        chk({tag, ".almost_full"}, int'(almost_full), int'(af));
        chk({tag, ".almost_empty"}, int'(almost_empty), int'(ae));
        chk({tag, ".error"}, int'(fifo_error), int'(er));
    endtask

    initial begin
        //          init a b push pop din  chk dout v cnt e f af ae err
        vecs.push_back(mk(1, 3, 1, 0, 0, 'h00, 0, 'h00, 0, 0, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 'h0A, 0, 'h00, 0, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 'h15, 0, 'h00, 0, 2, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 'h2C, 0, 'h00, 0, 3, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 'h00, 1, 'h0A, 1, 2, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 'h00, 1, 'h15, 1, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 'h00, 1, 'h2C, 1, 0, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 'h00, 1, 'h2C, 0, 0, 1, 0, 0, 1, 0));
        // fill, overflow with 0x3F, drain, then one underflow
        vecs.push_back(mk(0, 0, 0, 1, 0, 'h01, 0, 'h00, 0, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 'h02, 0, 'h00, 0, 2, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 'h03, 0, 'h00, 0, 3, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 'h04, 0, 'h00, 0, 4, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 'h3F, 0, 'h00, 0, 4, 0, 1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 'h00, 1, 'h01, 1, 3, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 'h00, 1, 'h02, 1, 2, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 'h00, 1, 'h03, 1, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 'h00, 1, 'h04, 1, 0, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 'h00, 1, 'h04, 0, 0, 1, 0, 0, 1, 1));
        // init clears error; alto=0 disables almost_full, bajo=5 pins almost_empty;
        // push/pop in the init cycle are ignored
        vecs.push_back(mk(1, 0, 5, 1, 1, 'h33, 0, 'h00, 0, 0, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 'h21, 0, 'h00, 0, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 'h22, 0, 'h00, 0, 2, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 'h23, 0, 'h00, 0, 3, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 'h24, 0, 'h00, 0, 4, 0, 1, 0, 1, 0));
        // full with simultaneous push/pop across pointer wrap
        vecs.push_back(mk(0, 0, 0, 1, 1, 'h11, 1, 'h21, 1, 4, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 'h11, 1, 'h22, 1, 4, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 'h11, 1, 'h23, 1, 4, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 'h11, 1, 'h24, 1, 4, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 'h11, 1, 'h11, 1, 4, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 'h11, 1, 'h11, 1, 4, 0, 1, 0, 1, 0));
        // empty with push and pop: push taken, underflow flagged
        vecs.push_back(mk(1, 3, 1, 0, 0, 'h00, 0, 'h00, 0, 0, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 'h05, 0, 'h00, 0, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 'h00, 1, 'h05, 1, 0, 1, 0, 0, 1, 1));

        reset_L     = 1'b0;
        init        = 1'b0;
        umbral_alto = '0;
        umbral_bajo = '0;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.data_in = '0;
        #12;
        chk_status("reset", 0, 1, 0, 0, 1, 0);
        chk("reset.valid", int'(bus.valid_out), 0);
        chk("reset.dout", int'(bus.data_out), 0);
        @(negedge clk);
        reset_L = 1'b1;

        foreach (vecs[k]) begin
            @(negedge clk);
            init        = vecs[k].init;
            umbral_alto = vecs[k].alto;
            umbral_bajo = vecs[k].bajo;
            bus.push    = vecs[k].push;
            bus.pop     = vecs[k].pop;
            bus.data_in = vecs[k].din;
            @(posedge clk);
            #1;
            chk_status($sformatf("v%0d", k), int'(vecs[k].cnt), vecs[k].empty,
                       vecs[k].full, vecs[k].af, vecs[k].ae, vecs[k].err);
            chk($sformatf("v%0d.valid", k), int'(bus.valid_out), int'(vecs[k].valid));
            if (vecs[k].chk_d)
                chk($sformatf("v%0d.dout", k), int'(bus.data_out), int'(vecs[k].dout));
        end

        // Underflow burst: error stays sticky, counter saturates at 15.
`ifdef FIFO_ERR_COUNT_EN
        chk("errcnt.one", int'(err_count), 1);
`endif
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 1'b1, 0);
        chk("burst.error", int'(fifo_error), 1);
        chk("burst.valid", int'(bus.valid_out), 0);
        chk("burst.count", int'(count), 0);
`ifdef FIFO_ERR_COUNT_EN
        chk("errcnt.sat", int'(err_count), 15);
`endif
        drive(1'b1, 1'b0, 1'b0, 0);
        chk("reinit.error", int'(fifo_error), 0);
`ifdef FIFO_ERR_COUNT_EN
        chk("errcnt.clr", int'(err_count), 0);
`endif

        // Asynchronous reset in the middle of a push/pop burst.
        drive(1'b0, 1'b1, 1'b0, 'h07);
        drive(1'b0, 1'b1, 1'b0, 'h08);
        drive(1'b0, 1'b1, 1'b1, 'h09);
        chk("burst.pre_rst_valid", int'(bus.valid_out), 1);
        chk("burst.pre_rst_dout", int'(bus.data_out), 'h07);
        #2;
        reset_L = 1'b0;
        #1;
        chk_status("async_rst", 0, 1, 0, 0, 1, 0);
        chk("async_rst.valid", int'(bus.valid_out), 0);
        chk("async_rst.dout", int'(bus.data_out), 0);
        @(posedge clk);
        #1;
        chk("async_rst.hold_count", int'(count), 0);
        @(negedge clk);
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        reset_L  = 1'b1;
        @(posedge clk);
        #1;
        chk_status("post_rst", 0, 1, 0, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
